// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter and sequencer that shares one UART transmitter between
// NREQ byte requesters. Each accepted byte is launched into the transmitter,
// and the arbiter waits for tx_done (or a timeout) before the next grant.
// The free-running baud enable for the UART TX/RX datapath also lives here.
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [8*NREQ-1:0]        req_data_i,
   output logic [NREQ-1:0]          req_ready_o,
   output logic                     enb_o,
   output logic                     tx_start_o,
   output logic [7:0]               tx_data_o,
   input  logic                     tx_done_i,
   output logic [$clog2(NREQ)-1:0]  grant_id_o,
   output logic                     busy_o,
   output logic                     tx_err_o
);

   localparam int IDW = $clog2(NREQ);
   localparam int BW  = $clog2(CLKS_PER_BIT);
   localparam int TW  = $clog2(TIMEOUT_CYC);

   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]  BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [IDW-1:0] PTR_RST   = IDW'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_LAUNCH,
      ST_WAIT
   } state_e;

   state_e            state_q;
   logic [IDW-1:0]    ptr_q;
   logic [IDW-1:0]    grant_id_q;
   logic [NREQ-1:0]   req_ready_q;
   logic              tx_start_q;
   logic [7:0]        tx_data_q;
   logic              busy_q;
   logic              tx_err_q;
   logic [TW-1:0]     tmo_q;

   logic [BW-1:0]     baud_q;
   logic              enb_q;

   logic              grant_hit_d;
   logic [IDW-1:0]    grant_idx_d;
   int                cand_d;
   logic [7:0]        req_bytes [NREQ];

   // Free-running baud divider; enb is registered one count early so it is
   // high exactly while the count sits at CLKS_PER_BIT-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q <= '0;
         enb_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values.
         baud_q <= (baud_q == BAUD_LAST) ? '0 : baud_q + 1'b1;
         enb_q  <= (baud_q == BAUD_PRE);
      end
   end

   // Round-robin search: first valid requester after ptr_q, wrapping
   // explicitly at NREQ-1 so indices >= NREQ can never be selected.
   always_comb begin
      // NOTE: defaults first so no path leaves these unassigned (no latch).
      grant_hit_d = 1'b0;
      grant_idx_d = '0;
      cand_d      = 0;
      // Walk from the farthest to the nearest position; the last hit wins,
      // which leaves the nearest valid requester selected.
      for (int k = NREQ; k >= 1; k--) begin
         cand_d = int'(ptr_q) + k;
         if (cand_d >= NREQ) begin
            cand_d = cand_d - NREQ;
         end
         if (req_valid_i[cand_d[IDW-1:0]]) begin
            grant_hit_d = 1'b1;
            grant_idx_d = cand_d[IDW-1:0];
         end
      end
   end

   // Split the packed request data bus into one byte per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_bytes[i] = req_data_i[8*i +: 8];
      end
   end

   // Arbitration sequencer; all port-facing values are registered here so no
   // input reaches an output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= PTR_RST;
         grant_id_q  <= '0;
         req_ready_q <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         busy_q      <= 1'b0;
         tx_err_q    <= 1'b0;
         tmo_q       <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them below.
         req_ready_q <= '0;
         tx_start_q  <= 1'b0;
         tx_err_q    <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (grant_hit_d) begin
                  grant_id_q               <= grant_idx_d;
                  req_ready_q[grant_idx_d] <= 1'b1;
                  busy_q                   <= 1'b1;
                  state_q                  <= ST_GRANT;
               end
            end

            ST_GRANT: begin
               if (req_valid_i[grant_id_q]) begin
                  tx_data_q  <= req_bytes[grant_id_q];
                  tx_start_q <= 1'b1;
                  state_q    <= ST_LAUNCH;
               end else begin
                  // Requester withdrew during its grant: drop it and keep
                  // the search position where it was.
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            ST_LAUNCH: begin
               tmo_q   <= '0;
               state_q <= ST_WAIT;
            end

            ST_WAIT: begin
               if (tx_done_i) begin
                  // Completion takes priority over a coincident timeout.
                  ptr_q   <= grant_id_q;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (tmo_q == TMO_LAST) begin
                  tx_err_q <= 1'b1;
                  ptr_q    <= grant_id_q;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign enb_o       = enb_q;
   assign tx_start_o  = tx_start_q;
   assign tx_data_o   = tx_data_q;
   assign grant_id_o  = grant_id_q;
   assign busy_o      = busy_q;
   assign tx_err_o    = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter: reset values and baud phase, single
// transfer, round-robin order, withdrawn grant, timeout, done/timeout
// collision and tx_done outside WAIT. Outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

   localparam int NREQ         = 4;
   localparam int CLKS_PER_BIT = 16;
   localparam int TIMEOUT_CYC  = 16;
   localparam int IDW          = $clog2(NREQ);

   localparam logic [7:0] B0 = 8'h3C;
   localparam logic [7:0] B1 = 8'h5A;
   localparam logic [7:0] B2 = 8'hA5;
   localparam logic [7:0] B3 = 8'hC3;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [8*NREQ-1:0]   req_data;
   logic [NREQ-1:0]     req_ready;
   logic                enb;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_done;
   logic [IDW-1:0]      grant_id;
   logic                busy;
   logic                tx_err;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .NREQ         (NREQ),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .TIMEOUT_CYC  (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .enb_o       (enb),
      .tx_start_o  (tx_start),
      .tx_data_o   (tx_data),
      .tx_done_i   (tx_done),
      .grant_id_o  (grant_id),
      .busy_o      (busy),
      .tx_err_o    (tx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // All outputs must read zero (used while rst is asserted).
   task automatic check_all_zero(input string tag);
      check({tag, " req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " enb"},       32'(enb),       32'd0);
      check({tag, " tx_start"},  32'(tx_start),  32'd0);
      check({tag, " tx_data"},   32'(tx_data),   32'd0);
      check({tag, " grant_id"},  32'(grant_id),  32'd0);
      check({tag, " busy"},      32'(busy),      32'd0);
      check({tag, " tx_err"},    32'(tx_err),    32'd0);
   endtask

   // Expects GRANT on the next sample and LAUNCH on the one after, then
   // presents valid_after to the requesters.
   task automatic grant_phase(input int id, input logic [7:0] data,
                              input logic [NREQ-1:0] valid_after);
      step();
      check($sformatf("grant%0d req_ready", id), 32'(req_ready), 32'(1) << id);
      check($sformatf("grant%0d grant_id", id),  32'(grant_id),  32'(id));
      check($sformatf("grant%0d busy", id),      32'(busy),      32'd1);
      check($sformatf("grant%0d tx_start", id),  32'(tx_start),  32'd0);
      check($sformatf("grant%0d tx_err", id),    32'(tx_err),    32'd0);
      step();
      check($sformatf("launch%0d req_ready", id), 32'(req_ready), 32'd0);
      check($sformatf("launch%0d tx_start", id),  32'(tx_start),  32'd1);
      check($sformatf("launch%0d tx_data", id),   32'(tx_data),   32'(data));
      req_valid = valid_after;
   endtask

   // Spends n samples in WAIT, pulses tx_done, and expects IDLE without error.
   task automatic finish_done(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check($sformatf("wait%0d busy", i),      32'(busy),      32'd1);
         check($sformatf("wait%0d tx_start", i),  32'(tx_start),  32'd0);
         check($sformatf("wait%0d req_ready", i), 32'(req_ready), 32'd0);
         check($sformatf("wait%0d tx_err", i),    32'(tx_err),    32'd0);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("done busy",      32'(busy),      32'd0);
      check("done tx_err",    32'(tx_err),    32'd0);
      check("done req_ready", 32'(req_ready), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      tx_done   = 1'b0;
      req_data  = {B3, B2, B1, B0};

      // Reset values, then baud phase from release: pulses at counts 15 and 31.
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         step();
         check($sformatf("enb k=%0d", k), 32'(enb), 32'((k == 15) || (k == 31)));
      end
      check("idle busy", 32'(busy), 32'd0);

      // Single request from requester 2.
      req_valid = 4'b0100;
      grant_phase(2, B2, 4'b0000);
      finish_done(3);

      // Reset in the middle of WAIT (ptr=2, so requester 1 is granted).
      req_valid = 4'b0010;
      grant_phase(1, B1, 4'b0000);
      step();
      step();
      check("prerst busy",    32'(busy),     32'd1);
      check("prerst tx_data", 32'(tx_data),  32'(B1));
      check("prerst grant",   32'(grant_id), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("async rst");
      step();
      step();
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("rel enb k=%0d", k), 32'(enb), 32'(k == 15));
         check($sformatf("rel quiet k=%0d", k),
               32'({req_ready, tx_start, tx_err, busy}), 32'd0);
      end
      req_valid = 4'b1010;
      grant_phase(1, B1, 4'b0000);
      finish_done(2);

      // Round-robin with all requesters valid: 0,1,2,3,0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b1111;
      grant_phase(0, B0, 4'b1111);
      finish_done(4);
      grant_phase(1, B1, 4'b1111);
      finish_done(4);
      grant_phase(2, B2, 4'b1111);
      finish_done(4);
      grant_phase(3, B3, 4'b1111);
      finish_done(4);
      grant_phase(0, B0, 4'b0000);
      finish_done(4);

      // Withdrawn in GRANT (ptr=0): requester 1 granted, drops; search restarts at 1.
      req_valid = 4'b0110;
      step();
      check("wd req_ready", 32'(req_ready), 32'b0010);
      check("wd grant_id",  32'(grant_id),  32'd1);
      req_valid = 4'b0000;
      step();
      check("wd tx_start",  32'(tx_start),  32'd0);
      check("wd busy",      32'(busy),      32'd0);
      check("wd req_ready", 32'(req_ready), 32'd0);
      req_valid = 4'b1010;
      grant_phase(1, B1, 4'b0000);
      finish_done(2);

      // Timeout on requester 2; requester 3 is next after ptr moves to 2.
      req_valid = 4'b0100;
      grant_phase(2, B2, 4'b1001);
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("tmo k=%0d tx_err", k), 32'(tx_err), 32'd0);
         check($sformatf("tmo k=%0d busy", k),   32'(busy),   32'd1);
      end
      step();
      check("tmo tx_err",    32'(tx_err),    32'd1);
      check("tmo busy",      32'(busy),      32'd0);
      check("tmo req_ready", 32'(req_ready), 32'd0);
      grant_phase(3, B3, 4'b0000);

      // tx_done on the timeout cycle: done wins, no tx_err.
      finish_done(16);

      // tx_done while IDLE is ignored.
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("idle done busy",     32'(busy),      32'd0);
      check("idle done req",      32'(req_ready), 32'd0);
      check("idle done tx_start", 32'(tx_start),  32'd0);
      check("idle done tx_err",   32'(tx_err),    32'd0);
      step();
      check("idle done busy2",    32'(busy),      32'd0);

      // ptr=3 after the collision, so requester 0 beats requester 3.
      req_valid = 4'b1001;
      grant_phase(0, B0, 4'b0000);
      finish_done(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter between up to NREQ byte requesters. It accepts bytes over per-requester valid/ready handshakes, launches each byte into the transmitter and waits for completion. It also generates the free-running baud-rate enable pulse used by the UART transmitter and receiver. It sits between the host-side byte sources and the UART TX/RX datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- CLKS_PER_BIT, 16: clk cycles per baud enable pulse, ≥2
- TIMEOUT_CYC, 4096: max cycles to wait for tx_done before abort, ≥16
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  requester i has a byte pending; held until handshake
- req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i]
- req_ready  output  NREQ  one-hot, one-cycle grant/accept strobe
- enb  output  1  baud enable, one-cycle pulse every CLKS_PER_BIT clocks
- tx_start  output  1  one-cycle launch strobe to transmitter
- tx_data  output  8  byte to transmit, stable from GRANT until next grant
- tx_done  input  1  one-cycle pulse from transmitter, stop bit sent
- grant_id  output  clog2(NREQ)  index of current/last granted requester
- busy  output  1  high in any state other than IDLE
- tx_err  output  1  one-cycle pulse on timeout abort

## Operation
- Baud counter: free-running 0..CLKS_PER_BIT-1; enb=1 in the cycle the count equals CLKS_PER_BIT-1; wraps to 0; independent of arbiter state.
- Priority pointer ptr = last granted index; search order is ptr+1, ptr+2, … mod NREQ. After reset ptr=NREQ-1, so requester 0 has first priority.
- States: IDLE, GRANT, LAUNCH, WAIT.
- IDLE: if any req_valid, select first valid in search order, set grant_id, go GRANT. Otherwise stay.
- GRANT: req_ready[grant_id]=1 for exactly this cycle.
  - If req_valid[grant_id] is still 1: capture req_data slice into tx_data and go LAUNCH.
  - If it dropped (protocol violation): discard, go IDLE with ptr unchanged.
- LAUNCH: tx_start=1 for one cycle; clear timeout counter; go WAIT.
- WAIT: increment timeout counter each cycle.
  - tx_done=1: ptr<=grant_id, go IDLE.
  - Counter reaches TIMEOUT_CYC-1 without tx_done: tx_err=1 for one cycle, ptr<=grant_id, go IDLE.
  - tx_done in the same cycle as the timeout: done wins, no tx_err.
- tx_done outside WAIT is ignored.
- New req_valid arrivals during GRANT/LAUNCH/WAIT are not sampled until the next IDLE.
- Requester ordering for NREQ not a power of two: wrap explicitly at NREQ-1 → 0; indices ≥NREQ are never granted.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state=IDLE, ptr=NREQ-1, baud counter=0.
  - req_ready=0, enb=0, tx_start=0, tx_data=0, grant_id=0, busy=0, tx_err=0.
- All outputs are registered; no combinational input→output path.
- Latency: req_valid high at edge t (state IDLE) → req_ready and busy high at t+1 → tx_start at t+2 → WAIT from t+3.
- Back-to-back: tx_done at edge d → IDLE at d+1 → next req_ready at d+2 at the earliest.
- Reset mid-transfer: abort immediately; no tx_err, no req_ready, no tx_start after reset release; first grant after release goes to the lowest valid index.
- enb phase is unaffected by arbitration; only rst restarts it.

## Test plan
- Reset: assert rst mid-WAIT → all outputs 0 the same cycle; after release, enb first pulses on the 16th clk (count 15).
- Single request: req_valid[2]=1, data 0xA5 → req_ready=0100 one cycle, tx_start next cycle with tx_data=0xA5; tx_done → busy=0.
- Round-robin: all four valid continuously, tx_done 5 cycles after each tx_start → grants 0,1,2,3,0 in order; each req_ready exactly one cycle.
- Valid withdrawn in GRANT: drop req_valid[1] in the GRANT cycle → no tx_start, back to IDLE, next grant from the same search position.
- Timeout: TIMEOUT_CYC=16, never pulse tx_done → tx_err one cycle, 16 cycles after WAIT entry; next requester granted afterwards.
- Done/timeout collision: tx_done on the timeout cycle → no tx_err; a tx_done pulse in IDLE → no state change.
